layer_serializer: RTL and testbench

Parametrised parallel-to-serial converter placed between a neural-network layer and the next layer or classifier stage. Captures one layer output vector of NUM_WORDS fixed-point words in a single cycle, then emits the words one per handshake on a valid/ready stream. Adds backpressure, a last-word marker, a word index, overrun detection and optional double buffering for gap-free streaming.

---
 rtl/layer_serializer_pkg.sv | 8 +
 rtl/layer_serializer_ser_vec_reg.sv | 24 ++
 rtl/layer_serializer.sv | 83 ++++++++
 tb/tb_layer_serializer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/layer_serializer_pkg.sv
// layer_serializer_pkg: state encoding, default word width and per-layer vector sizes
// shared by the layer serializer and its vector register.
package layer_serializer_pkg;
  typedef enum logic {SER_IDLE = 1'b0, SER_SHIFT = 1'b1} ser_state_t;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int L1_NUM_WORDS = 30;
  localparam int L2_NUM_WORDS = 10;
endpackage

// File: rtl/layer_serializer_ser_vec_reg.sv
// ser_vec_reg: vector load/shift register exposing its head word; shifting moves
// the next word toward the head end selected by LSB_FIRST.
module ser_vec_reg #(
  parameter int NUM_WORDS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LSB_FIRST  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_load,
  input  logic                            i_shift,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] o_vec,
  output logic [DATA_WIDTH-1:0]           o_head
);
  logic [NUM_WORDS*DATA_WIDTH-1:0] r_vec;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vec <= '0;
    else if (i_load) r_vec <= i_data;
    else if (i_shift) r_vec <= (LSB_FIRST != 0) ? r_vec >> DATA_WIDTH : r_vec << DATA_WIDTH;
  end
  assign o_vec  = r_vec;
  assign o_head = (LSB_FIRST != 0) ? r_vec[DATA_WIDTH-1:0] : r_vec[NUM_WORDS*DATA_WIDTH-1 -: DATA_WIDTH];
endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: captures a layer output vector and streams it one word per handshake.
// Define SER_DBUF_EN to add a shadow vector for gap-free back-to-back streaming.
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter  int NUM_WORDS  = L1_NUM_WORDS,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int LSB_FIRST  = 1,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [IDX_W-1:0]                out_idx,
  output logic                            busy,
  output logic                            overrun
);
  ser_state_t r_state;
  logic [IDX_W-1:0] r_idx;
  logic r_overrun;
  logic [DATA_WIDTH-1:0] w_head;
  logic [NUM_WORDS*DATA_WIDTH-1:0] w_load_data, w_hold_vec;
  logic w_hs, w_done, w_cap, w_hold_load;
  assign out_valid = r_state == SER_SHIFT;
  assign out_last  = out_valid && r_idx == IDX_W'(NUM_WORDS - 1);
  assign out_idx   = r_idx;
  assign out_data  = out_valid ? w_head : '0;
  assign overrun   = r_overrun;
  assign w_hs      = out_valid && out_ready;
  assign w_done    = w_hs && out_last;
  assign w_cap     = in_valid && in_ready;
`ifdef SER_DBUF_EN
  logic r_shadow_full, w_shadow_load;
  logic [NUM_WORDS*DATA_WIDTH-1:0] w_shadow_vec;
  logic [DATA_WIDTH-1:0] w_shadow_head;
  assign in_ready      = !r_shadow_full;
  assign busy          = out_valid || r_shadow_full;
  // a capture coinciding with the final handshake of an empty-shadow stream reloads directly
  assign w_shadow_load = w_cap && out_valid && !w_done;
  assign w_hold_load   = (w_cap && !out_valid) || (w_done && (r_shadow_full || w_cap));
  assign w_load_data   = r_shadow_full ? w_shadow_vec : in_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_shadow_full <= 1'b0;
    else if (w_shadow_load) r_shadow_full <= 1'b1;
    else if (w_done) r_shadow_full <= 1'b0;
  end
  ser_vec_reg #(.NUM_WORDS(NUM_WORDS), .DATA_WIDTH(DATA_WIDTH), .LSB_FIRST(LSB_FIRST)) u_shadow (
    .clk(clk), .rst(rst), .i_load(w_shadow_load), .i_shift(1'b0), .i_data(in_data),
    .o_vec(w_shadow_vec), .o_head(w_shadow_head)
  );
`else
  assign in_ready    = r_state == SER_IDLE;
  assign busy        = out_valid;
  assign w_hold_load = w_cap;
  assign w_load_data = in_data;
`endif
  ser_vec_reg #(.NUM_WORDS(NUM_WORDS), .DATA_WIDTH(DATA_WIDTH), .LSB_FIRST(LSB_FIRST)) u_hold (
    .clk(clk), .rst(rst), .i_load(w_hold_load), .i_shift(w_hs), .i_data(w_load_data),
    .o_vec(w_hold_vec), .o_head(w_head)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SER_IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= in_valid && !in_ready;
      if (w_hold_load) begin
        r_state <= SER_SHIFT;
        r_idx   <= '0;
      end else if (w_done) begin
        r_state <= SER_IDLE;
        r_idx   <= '0;
      end else if (w_hs) r_idx <= r_idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: randomized and directed stimulus checked against a word-level
// model of vector capture, emission, shadowing and overrun.
module tb_layer_serializer;
  localparam int NW = 4, DW = 16, IW = $clog2(NW);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [NW*DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, overrun;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic b_in_ready, b_out_valid, b_out_last, b_busy, b_overrun;
  logic [DW-1:0] b_out_data;
  logic [IW-1:0] b_out_idx;
  int n_err = 0, n_chk = 0;
  bit m_act, m_sh, m_ovr;
  int m_idx;
  logic [NW*DW-1:0] m_vec, m_shv;
  localparam logic [NW*DW-1:0] VA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [NW*DW-1:0] VB = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
  localparam logic [NW*DW-1:0] VC = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};

  always #5 clk = ~clk;

  layer_serializer #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .LSB_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_idx(out_idx), .busy(busy), .overrun(overrun)
  );
  layer_serializer #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last),
    .out_idx(b_out_idx), .busy(b_busy), .overrun(b_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
`ifdef SER_DBUF_EN
    return !m_sh;
`else
    return !m_act;
`endif
  endfunction

  task automatic model_reset();
    m_act = 0; m_sh = 0; m_ovr = 0; m_idx = 0; m_vec = '0; m_shv = '0;
  endtask

  task automatic check_all();
    logic [DW-1:0] e_lsb, e_msb;
    e_lsb = m_act ? m_vec[m_idx*DW +: DW] : '0;
    e_msb = m_act ? m_vec[(NW-1-m_idx)*DW +: DW] : '0;
    chk("in_ready", in_ready, exp_rdy());
    chk("out_valid", out_valid, m_act);
    chk("out_data", out_data, e_lsb);
    chk("out_idx", out_idx, m_idx);
    chk("out_last", out_last, m_act && m_idx == NW-1);
    chk("busy", busy, m_act || m_sh);
    chk("overrun", overrun, m_ovr);
    chk("msb_data", b_out_data, e_msb);
    chk("msb_last", b_out_last, m_act && m_idx == NW-1);
  endtask

  task automatic model_next();
    bit rdy, cap, done;
    rdy = exp_rdy();
    cap = in_valid && rdy;
    done = 0;
    m_ovr = in_valid && !rdy;
    if (m_act && out_ready) begin
      if (m_idx == NW-1) begin done = 1; m_act = 0; m_idx = 0; end
      else m_idx++;
    end
    if (done && m_sh) begin m_act = 1; m_vec = m_shv; m_sh = 0; end
    if (cap) begin
      if (!m_act) begin m_act = 1; m_vec = in_data; m_idx = 0; end
      else begin m_sh = 1; m_shv = in_data; end
    end
  endtask

  task automatic cycle(input logic iv, input logic [NW*DW-1:0] v, input logic ordy);
    check_all();
    in_valid = iv; in_data = v; out_ready = ordy;
    model_next();
    @(negedge clk);
  endtask

  initial begin
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst = 0;
    cycle(1, VA, 1);
    repeat (5) cycle(0, '0, 1);
    cycle(1, VA, 1);
    foreach (pat[i]) cycle(0, '0, pat[i]);
    repeat (4) cycle(0, '0, 1);
    cycle(1, VA, 1);
    cycle(0, '0, 1);
    cycle(1, VB, 1);
    cycle(1, VC, 1);
    repeat (10) cycle(0, '0, 1);
    cycle(1, VA, 1);
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    chk("pre_rst_idx", out_idx, 2);
    #2 rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle(1, VB, 1);
    repeat (6) cycle(0, '0, 1);
    repeat (1500) cycle($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    repeat (8) cycle(0, '0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
